// File: rtl/elevator_pkg.sv
// Shared elevator encodings: scheduler state/direction codes and the default floor count.
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS = 3;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_HOLD = 2'b11
    } dir_e;

endpackage

// File: rtl/nearest_call_finder.sv
// Combinational helper: nearest pending call strictly above / below the last known floor.
module nearest_call_finder
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [NUM_FLOORS-1:0] last_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic [NUM_FLOORS-1:0] nearest_above,
    output logic [NUM_FLOORS-1:0] nearest_below
);

    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] cand_above;
    logic [NUM_FLOORS-1:0] cand_below;

    // Floor gi is above last_floor when last_floor sits in a lower bit, below when in a higher bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
            localparam logic [NUM_FLOORS-1:0] SELF  = NUM_FLOORS'(1) << gi;
            localparam logic [NUM_FLOORS-1:0] LOWER = SELF - NUM_FLOORS'(1);
            assign above_mask[gi] = |(last_floor & LOWER);
            assign below_mask[gi] = |(last_floor & ~(LOWER | SELF));
        end
    endgenerate

    assign cand_above = pending & above_mask;
    assign cand_below = pending & below_mask;
    assign any_above  = |cand_above;
    assign any_below  = |cand_below;

    // Last hit wins: descending scan keeps the lowest above, ascending keeps the highest below.
    always_comb begin
        nearest_above = '0;
        nearest_below = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (cand_above[i]) begin
                nearest_above    = '0;
                nearest_above[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (cand_below[i]) begin
                nearest_below    = '0;
                nearest_below[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// SCAN call scheduler: latches floor calls and picks the next target for the movement FSM.
// Optional SOS_CLEAR_EN: an active SOS wipes all pending calls and ignores new ones.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
    input  logic                  clk,
    input  logic                  button_reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic                  arrived,
    input  logic                  sos_mode,
    input  logic                  weight_limit_exceeded,
    output logic [NUM_FLOORS-1:0] call_led,
    output logic [NUM_FLOORS-1:0] target_floor,
    output logic                  target_valid,
    output logic [1:0]            dir
);

    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] last_floor_q, last_floor_d;
    logic [NUM_FLOORS-1:0] target_q, target_d;
    logic                  target_valid_q, target_valid_d;
    dir_e                  state_q, state_d;

    logic                  any_above, any_below;
    logic [NUM_FLOORS-1:0] nearest_above, nearest_below;

    nearest_call_finder #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_finder (
        .pending       (pending_q),
        .last_floor    (last_floor_q),
        .any_above     (any_above),
        .any_below     (any_below),
        .nearest_above (nearest_above),
        .nearest_below (nearest_below)
    );

    // The door floor is the fresh cur_floor when present, so arrival and floor change may coincide.
    always_comb begin
        last_floor_d = (cur_floor != '0) ? cur_floor : last_floor_q;
        pending_d    = pending_q | call_req;
`ifdef SOS_CLEAR_EN
        if (sos_mode) begin
            pending_d = '0;
        end
`endif
        if (arrived) begin
            pending_d = pending_d & ~last_floor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = '0;
        if (sos_mode || weight_limit_exceeded) begin
            state_d = DIR_HOLD;
        end else begin
            case (state_q)
                DIR_HOLD: state_d = DIR_IDLE;
                DIR_DOWN: begin
                    if (any_below)      state_d = DIR_DOWN;
                    else if (any_above) state_d = DIR_UP;
                    else                state_d = DIR_IDLE;
                end
                default: begin
                    if (any_above)      state_d = DIR_UP;
                    else if (any_below) state_d = DIR_DOWN;
                    else                state_d = DIR_IDLE;
                end
            endcase
        end

        // Leaving HOLD spends one edge in a blank IDLE before targets are offered again.
        case (state_d)
            DIR_UP:   target_d = nearest_above;
            DIR_DOWN: target_d = nearest_below;
            DIR_IDLE: begin
                if (state_q != DIR_HOLD && pending_q == last_floor_q) begin
                    target_d = last_floor_q;
                end
            end
            default:  target_d = '0;
        endcase
        target_valid_d = |target_d;
    end

    always_ff @(posedge clk) begin
        if (button_reset) begin
            pending_q      <= '0;
            last_floor_q   <= NUM_FLOORS'(1);
            state_q        <= DIR_IDLE;
            target_q       <= '0;
            target_valid_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            last_floor_q   <= last_floor_d;
            state_q        <= state_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
        end
    end

    assign call_led     = pending_q;
    assign target_floor = target_q;
    assign target_valid = target_valid_q;
    assign dir          = state_q;

endmodule
